// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit.
// Holds the operation encoding driven by the decoder and the state
// encoding of the unit's sequencer.
package mdu_pkg;

  // Operation codes as presented on the op port.
  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } mdu_op_t;

  // Sequencer states: IDLE -> MUL | DIV -> FIX -> IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mult_div_unit_negate.sv
// Combinational two's-complement negation.
// Ports:
//   val - operand
//   neg - -val modulo 2^WIDTH
module mdu_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] neg
);

  assign neg = (~val) + WIDTH'(1);

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with Hi/Lo result registers.
// Multiplies RADIX_BITS multiplier bits per cycle, divides with a restoring
// divider (one quotient bit per cycle), then sign-corrects in FIX.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   valid_in, op      - start request and operation (mdu_op_t encoding)
//   src_a, src_b      - multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we      - MTHI/MTLO strobes writing wdata while idle
//   busy              - operation in flight
//   valid_out         - one-cycle pulse when hi/lo take a new result
//   hi, lo            - result registers
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             valid_out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MUL_CYCLES = WIDTH / RADIX_BITS;
  localparam int CW         = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  generate
    if ((WIDTH % RADIX_BITS) != 0) begin : g_bad_radix
      $error("mult_div_unit: RADIX_BITS must divide WIDTH");
    end
  endgenerate

  mdu_state_t         state;
  mdu_op_t            op_t;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mp;       // multiplier, reused as the divisor
  logic [2*WIDTH-1:0] mc;       // shifted multiplicand
  logic [2*WIDTH-1:0] acc;      // product, or {remainder, quotient}
  logic [WIDTH-1:0]   raw_a;    // unmodified dividend for divide-by-zero
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic               div_zero;

  logic               op_signed;
  logic               op_div;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   neg_a;
  logic [WIDTH-1:0]   neg_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] pp;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] neg_prod;
  logic [WIDTH-1:0]   neg_quo;
  logic [WIDTH-1:0]   neg_rem;
  logic [2*WIDTH-1:0] corrected;

  assign op_t      = mdu_op_t'(op);
  assign op_signed = (op_t == OP_MULT) || (op_t == OP_DIV);
  assign op_div    = (op_t == OP_DIV) || (op_t == OP_DIVU);
  assign sign_a    = op_signed & src_a[WIDTH-1];
  assign sign_b    = op_signed & src_b[WIDTH-1];
  assign busy      = (state != S_IDLE);

  mdu_negate #(.WIDTH(WIDTH))   u_neg_a    (.val(src_a),            .neg(neg_a));
  mdu_negate #(.WIDTH(WIDTH))   u_neg_b    (.val(src_b),            .neg(neg_b));
  mdu_negate #(.WIDTH(2*WIDTH)) u_neg_prod (.val(acc),              .neg(neg_prod));
  mdu_negate #(.WIDTH(WIDTH))   u_neg_quo  (.val(acc[WIDTH-1:0]),   .neg(neg_quo));
  mdu_negate #(.WIDTH(WIDTH))   u_neg_rem  (.val(acc[2*WIDTH-1:WIDTH]), .neg(neg_rem));

  assign mag_a = sign_a ? neg_a : src_a;
  assign mag_b = sign_b ? neg_b : src_b;

  // One radix digit of the multiplier times the shifted multiplicand.
  assign pp = (2*WIDTH)'(mp[RADIX_BITS-1:0]) * mc;

  // Restoring trial subtraction on the remainder shifted left by one,
  // pulling in the next dividend bit; a borrow in diff[WIDTH] means restore.
  assign diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mp};

  // Final result after sign correction; divide-by-zero bypasses correction.
  always_comb begin
    corrected = acc;
    if (is_div && div_zero) begin
      corrected = {raw_a, {WIDTH{1'b1}}};
    end else if (is_div) begin
      corrected = {(neg_hi ? neg_rem : acc[2*WIDTH-1:WIDTH]),
                   (neg_lo ? neg_quo : acc[WIDTH-1:0])};
    end else if (neg_lo) begin
      corrected = neg_prod;
    end
  end

  // Sequencer and datapath registers. FIX takes two cycles: the first
  // registers the corrected result so the wide negation stays off the
  // hi/lo write path, the second commits it and pulses valid_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mp        <= '0;
      mc        <= '0;
      acc       <= '0;
      raw_a     <= '0;
      is_div    <= 1'b0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      div_zero  <= 1'b0;
      valid_out <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (valid_in) begin
            cnt      <= '0;
            mp       <= mag_b;
            mc       <= {{WIDTH{1'b0}}, mag_a};
            acc      <= op_div ? {{WIDTH{1'b0}}, mag_a} : '0;
            raw_a    <= src_a;
            is_div   <= op_div;
            neg_lo   <= sign_a ^ sign_b;
            neg_hi   <= op_div ? sign_a : (sign_a ^ sign_b);
            div_zero <= op_div && (src_b == '0);
            state    <= op_div ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
          acc <= acc + pp;
          mp  <= mp >> RADIX_BITS;
          mc  <= mc << RADIX_BITS;
          if (cnt == MUL_LAST) begin
            cnt   <= '0;
            state <= S_FIX;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DIV: begin
          if (!diff[WIDTH]) begin
            acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          end else begin
            acc <= {acc[2*WIDTH-2:0], 1'b0};
          end
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            state <= S_FIX;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_FIX: begin
          if (cnt == '0) begin
            acc <= corrected;
            cnt <= CW'(1);
          end else begin
            hi        <= acc[2*WIDTH-1:WIDTH];
            lo        <= acc[WIDTH-1:0];
            valid_out <= 1'b1;
            cnt       <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit at WIDTH=32, RADIX_BITS=8.
// Stimulus pushes hand-computed expected results into a scoreboard queue;
// a monitor pops and compares whenever valid_out is seen.
module tb_mult_div_unit;

  localparam int MUL_LAT = 6;
  localparam int DIV_LAT = 34;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        valid_out;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          acc_edge;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  mult_div_unit #(.WIDTH(32), .RADIX_BITS(8)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .op(op),
    .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .valid_out(valid_out), .hi(hi), .lo(lo)
  );

  // Free-running clock and edge counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Hard time limit so the bench can never hang.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every completion must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && valid_out) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected valid_out: got hi=0x%08h lo=0x%08h expected none", hi, lo);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("result hi", hi, e.hi);
        checkOutput("result lo", lo, e.lo);
        checkOutput("latency", 32'(cyc - e.acc_edge), 32'(e.lat));
        checkOutput("busy at valid_out", {31'd0, busy}, 32'd0);
      end
    end
  end

  // Issue one operation at the next rising edge; caller must be away from
  // the edge and the unit must be idle at that edge.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] eh,
                               input logic [31:0] el, input int lat,
                               input bit push);
    exp_t e;
    valid_in = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    if (push) begin
      e.hi = eh;
      e.lo = el;
      e.lat = lat;
      e.acc_edge = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  // Wait for all outstanding expectations to be consumed, bounded.
  task automatic waitDrain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Wait for a valid_out pulse, bounded; returns at that negedge.
  task automatic waitValid();
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid_out) break;
    end
    total++;
    if (i == 100) begin
      bad++;
      $display("[TB] FAIL wait valid_out: got timeout expected pulse");
    end
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset valid_out", {31'd0, valid_out}, 32'd0);
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Signed multiply, then an unsigned one issued in the valid_out cycle.
    applyStimulus(2'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, MUL_LAT, 1);
    waitValid();
    applyStimulus(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT, 1);
    waitDrain();
    applyStimulus(2'd1, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780, MUL_LAT, 1);
    waitDrain();
    applyStimulus(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, MUL_LAT, 1);
    waitDrain();

    // Divides, including signed overflow and divide by zero.
    applyStimulus(2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT, 1);
    waitDrain();
    applyStimulus(2'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, DIV_LAT, 1);
    waitDrain();
    applyStimulus(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT, 1);
    waitDrain();
    applyStimulus(2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, DIV_LAT, 1);
    waitDrain();
    applyStimulus(2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, DIV_LAT, 1);
    waitDrain();
    applyStimulus(2'd2, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, DIV_LAT, 1);
    waitDrain();

    // Start request and MTHI while busy are both ignored.
    applyStimulus(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT, 1);
    repeat (9) @(posedge clk);
    #1;
    valid_in = 1'b1; op = 2'd0; src_a = 32'd3; src_b = 32'd3;
    hi_we = 1'b1; wdata = 32'hDEAD;
    @(posedge clk);
    #1;
    valid_in = 1'b0; hi_we = 1'b0;
    waitDrain();
    checkOutput("hi after busy write", hi, 32'd2);

    // MTLO while idle.
    lo_we = 1'b1; wdata = 32'h1234;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    checkOutput("mtlo lo", lo, 32'h1234);
    checkOutput("mtlo hi", hi, 32'd2);
    @(negedge clk);

    // Reset in the middle of a multiply aborts it without a result.
    applyStimulus(2'd0, 32'd3, 32'd3, 32'd0, 32'd0, MUL_LAT, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort hi", hi, 32'd0);
    checkOutput("abort lo", lo, 32'd0);
    repeat (10) @(negedge clk);
    applyStimulus(2'd1, 32'd7, 32'd6, 32'd0, 32'd42, MUL_LAT, 1);
    waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
